// File: rtl/cluster_ctrl_pkg.sv
// Shared types and default sizing for the cluster slice sequencer.
// The watchdog feature is enabled by defining CLUSTER_CTRL_TIMEOUT_EN.
package cluster_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_WGHT,
        ST_WT_WGHT,
        ST_GAP1,
        ST_LD_IACT,
        ST_WT_IACT,
        ST_GAP2,
        ST_START,
        ST_WT_COMP,
        ST_WB,
        ST_NEXT,
        ST_DONE
    } ctrl_state_t;

    // Gap and writeback phase counters never exceed 255.
    localparam int PHASE_CNT_W = 8;

    localparam int DEF_NUM_ITER       = 3;
    localparam int DEF_ITER_BITWIDTH  = 4;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_WB_CYCLES      = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic logic is_wait(input ctrl_state_t s);
        return s inside {ST_WT_WGHT, ST_WT_IACT, ST_WT_COMP};
    endfunction

endpackage

// File: rtl/cluster_ctrl_rise.sv
// Rising-edge detector: registers a level and flags a 0->1 transition
// against the previous cycle's value.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/cluster_ctrl.sv
// Job sequencer for one GLB/router/PE cluster slice: weight load, iact load,
// then NUM_ITER start/writeback iterations. Optional watchdog: CLUSTER_CTRL_TIMEOUT_EN.
module cluster_ctrl
    import cluster_ctrl_pkg::*;
#(
    parameter int NUM_ITER       = DEF_NUM_ITER,
    parameter int ITER_BITWIDTH  = DEF_ITER_BITWIDTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int WB_CYCLES      = DEF_WB_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     abort,
    input  logic                     load_done,
    input  logic                     compute_done,
    output logic                     load_spad_ctrl,
    output logic                     load_spad_ctrl_iact,
    output logic                     start,
    output logic                     write_psum_ctrl,
    output logic                     busy,
    output logic                     done,
    output logic [ITER_BITWIDTH-1:0] iter_cnt,
    output logic                     error
);

    if (NUM_ITER < 1 || NUM_ITER > (2 ** ITER_BITWIDTH) - 1 ||
        GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
        WB_CYCLES < 1 || WB_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cluster_ctrl: illegal parameter combination");
    end

    localparam bit GAP_NONE = (GAP_CYCLES == 0);
    localparam logic [PHASE_CNT_W-1:0] GAP_LAST = PHASE_CNT_W'(GAP_NONE ? 0 : GAP_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] WB_LAST  = PHASE_CNT_W'(WB_CYCLES - 1);
    localparam logic [ITER_BITWIDTH-1:0] ITER_LAST = ITER_BITWIDTH'(NUM_ITER - 1);

    ctrl_state_t              state_q, state_d;
    logic [ITER_BITWIDTH-1:0] iter_q, iter_d;
    logic [PHASE_CNT_W-1:0]   phase_q, phase_d;
    logic                     load_rise;
    logic                     comp_rise;
    logic                     wdog_expired;

    // Levels stay high across phases, so only fresh rising edges advance the waits.
    rise_detect u_load_rise (
        .clk   (clk),
        .rst_n (reset),
        .level (load_done),
        .rise  (load_rise)
    );

    rise_detect u_comp_rise (
        .clk   (clk),
        .rst_n (reset),
        .level (compute_done),
        .rise  (comp_rise)
    );

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        phase_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_LD_WGHT;
                    iter_d  = '0;
                end
            end
            ST_LD_WGHT: state_d = ST_WT_WGHT;
            ST_WT_WGHT: if (load_rise) state_d = GAP_NONE ? ST_LD_IACT : ST_GAP1;
            ST_GAP1: begin
                if (phase_q == GAP_LAST) state_d = ST_LD_IACT;
                else                     phase_d = phase_q + 1'b1;
            end
            ST_LD_IACT: state_d = ST_WT_IACT;
            ST_WT_IACT: if (load_rise) state_d = GAP_NONE ? ST_START : ST_GAP2;
            ST_GAP2: begin
                if (phase_q == GAP_LAST) state_d = ST_START;
                else                     phase_d = phase_q + 1'b1;
            end
            ST_START:   state_d = ST_WT_COMP;
            ST_WT_COMP: if (comp_rise) state_d = ST_WB;
            ST_WB: begin
                if (phase_q == WB_LAST) state_d = ST_NEXT;
                else                    phase_d = phase_q + 1'b1;
            end
            ST_NEXT: begin
                if (iter_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    // Weights and iacts stay resident; only the compute loop repeats.
                    iter_d  = iter_q + 1'b1;
                    state_d = GAP_NONE ? ST_START : ST_GAP2;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (wdog_expired) begin
            state_d = ST_IDLE;
            iter_d  = '0;
            phase_d = '0;
        end
        if (abort) begin
            state_d = ST_IDLE;
            iter_d  = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            phase_q <= phase_d;
        end
    end

`ifdef CLUSTER_CTRL_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              error_q, error_d;

    assign wdog_expired = is_wait(state_q) && (wdog_q == WDOG_LAST);

    // Counter restarts whenever a wait state is (re)entered.
    always_comb begin
        wdog_d  = '0;
        error_d = error_q;
        if (is_wait(state_q) && (state_d == state_q)) wdog_d = wdog_q + 1'b1;
        if (wdog_expired && !abort) error_d = 1'b1;
        if ((state_q == ST_IDLE) && run && !abort) error_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign wdog_expired = 1'b0;
    assign error        = 1'b0;
`endif

    assign load_spad_ctrl      = (state_q == ST_LD_WGHT);
    assign load_spad_ctrl_iact = (state_q == ST_LD_IACT);
    assign start               = (state_q == ST_START);
    assign write_psum_ctrl     = (state_q == ST_WB);
    assign done                = (state_q == ST_DONE);
    assign busy                = !(state_q inside {ST_IDLE, ST_DONE});
    assign iter_cnt            = iter_q;

endmodule

// File: tb/tb_cluster_ctrl.sv
// Scoreboard bench for cluster_ctrl: a responder answers loads/computes,
// a monitor records observed events, and each test compares them to expectations.
module tb_cluster_ctrl;
    import cluster_ctrl_pkg::*;

    localparam int ITW = DEF_ITER_BITWIDTH;

    logic           clk;
    logic           reset;
    logic           run;
    logic           abort;
    logic           load_done;
    logic           compute_done;
    logic           load_spad_ctrl;
    logic           load_spad_ctrl_iact;
    logic           start;
    logic           write_psum_ctrl;
    logic           busy;
    logic           done;
    logic [ITW-1:0] iter_cnt;
    logic           error;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];
    int ld_timer = 0;
    int cd_timer = 0;
    bit ld_hold = 0;
    bit cd_off = 0;
    int done_cnt = 0;
    int wb_len = 0;
    int wb_iter = 0;

    cluster_ctrl #(
        .NUM_ITER       (DEF_NUM_ITER),
        .ITER_BITWIDTH  (ITW),
        .GAP_CYCLES     (DEF_GAP_CYCLES),
        .WB_CYCLES      (DEF_WB_CYCLES),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .abort               (abort),
        .load_done           (load_done),
        .compute_done        (compute_done),
        .load_spad_ctrl      (load_spad_ctrl),
        .load_spad_ctrl_iact (load_spad_ctrl_iact),
        .start               (start),
        .write_psum_ctrl     (write_psum_ctrl),
        .busy                (busy),
        .done                (done),
        .iter_cnt            (iter_cnt),
        .error               (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event codes: 1000 wload, 2000 iload, 3000+10*iter start,
    // 4000+10*iter+len writeback window, 5000 done.
    always @(negedge clk) begin
        if (load_spad_ctrl) obs_q.push_back(1000);
        if (load_spad_ctrl_iact) obs_q.push_back(2000);
        if (start) obs_q.push_back(3000 + 10 * int'(iter_cnt));
        if (write_psum_ctrl) begin
            wb_len++;
            wb_iter = int'(iter_cnt);
        end else if (wb_len > 0) begin
            obs_q.push_back(4000 + 10 * wb_iter + wb_len);
            wb_len = 0;
        end
        if (done) begin
            obs_q.push_back(5000);
            done_cnt++;
        end
        // Responder: PE cluster reports completion 5 cycles after each request.
        if (load_spad_ctrl || load_spad_ctrl_iact) begin
            ld_timer = 5;
            if (!ld_hold) load_done = 1'b0;
        end else if (ld_timer > 0) begin
            ld_timer--;
            if (ld_timer == 0) load_done = 1'b1;
        end
        if (start) begin
            cd_timer = cd_off ? 0 : 5;
            compute_done = 1'b0;
        end else if (cd_timer > 0) begin
            cd_timer--;
            if (cd_timer == 0) compute_done = 1'b1;
        end
    end

    task automatic push_job();
        exp_q.push_back(1000);
        exp_q.push_back(2000);
        for (int i = 0; i < DEF_NUM_ITER; i++) begin
            exp_q.push_back(3000 + 10 * i);
            exp_q.push_back(4000 + 10 * i + DEF_WB_CYCLES);
        end
        exp_q.push_back(5000);
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++;
        if (iter_cnt !== '0) begin errors++; $display("FAIL reset_iter: got %0d, expected 0", iter_cnt); end
        checks++;
        if ({load_spad_ctrl, load_spad_ctrl_iact, start, write_psum_ctrl} !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 0000",
                     {load_spad_ctrl, load_spad_ctrl_iact, start, write_psum_ctrl});
        end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", error); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: outputs idle");
    endtask

    task automatic test_nominal();
        int e, o, target;
        bit ok;
        target = done_cnt + 1;
        push_job();
        pulse_run();
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nominal_timeout: got %0d dones, expected %0d", done_cnt, target); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after: got %b, expected 0", busy); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL nominal_error: got %b, expected 0", error); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL nominal_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL nominal_seq: got %0d, expected %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL nominal_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_nominal: job complete");
    endtask

    task automatic test_stuck_load();
        int e, o, target;
        bit ok;
        ld_hold = 1'b1;
        load_done = 1'b0;
        @(negedge clk);
        target = done_cnt + 1;
        push_job();
        pulse_run();
        for (int i = 0; i < 200 && obs_q.size() < 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() !== 2) begin errors++; $display("FAIL stuck_hold_events: got %0d, expected 2", obs_q.size()); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stuck_hold_busy: got %b, expected 1", busy); end
        ld_hold = 1'b0;
        load_done = 1'b0;
        repeat (2) @(negedge clk);
        load_done = 1'b1;
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stuck_timeout: got %0d dones, expected %0d", done_cnt, target); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL stuck_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL stuck_seq: got %0d, expected %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL stuck_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_stuck_load: iact wait held until fresh edge");
    endtask

    task automatic test_abort();
        int e, o, target, dones;
        bit ok;
        exp_q.push_back(1000);
        exp_q.push_back(2000);
        exp_q.push_back(3000);
        exp_q.push_back(4000 + DEF_WB_CYCLES);
        exp_q.push_back(3010);
        pulse_run();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (start && iter_cnt == ITW'(1)) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_reach_iter1: got no start at iter 1, expected one"); end
        @(negedge clk);
        abort = 1'b1;
        dones = done_cnt;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        checks++;
        if (iter_cnt !== '0) begin errors++; $display("FAIL abort_iter: got %0d, expected 0", iter_cnt); end
        checks++;
        if (write_psum_ctrl !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got wb=%b done=%b, expected 0 0", write_psum_ctrl, done);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt !== dones) begin errors++; $display("FAIL abort_no_done: got %0d dones, expected %0d", done_cnt, dones); end
        target = done_cnt + 1;
        push_job();
        pulse_run();
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got %0d dones, expected %0d", done_cnt, target); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL abort_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL abort_seq: got %0d, expected %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_abort: aborted in iter 1, restart ran full job");
    endtask

    task automatic test_async_reset();
        int e, o, target;
        bit ok;
        pulse_run();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (write_psum_ctrl) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL areset_reach_wb: got no writeback, expected one"); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (write_psum_ctrl !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got wb=%b busy=%b, expected 0 0", write_psum_ctrl, busy);
        end
        checks++;
        if (iter_cnt !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_iter_done: got iter=%0d done=%b, expected 0 0", iter_cnt, done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        target = done_cnt + 1;
        push_job();
        pulse_run();
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL areset_restart_timeout: got %0d dones, expected %0d", done_cnt, target); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL areset_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL areset_seq: got %0d, expected %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL areset_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_async_reset: mid-writeback reset cleared, rerun complete");
    endtask

    task automatic test_back_to_back();
        int e, o, target, first_done, lw2;
        bit ok;
        target = done_cnt + 2;
        first_done = -1;
        lw2 = -1;
        push_job();
        push_job();
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done && first_done < 0) first_done = i;
            if (load_spad_ctrl && first_done >= 0 && lw2 < 0) lw2 = i;
        end
        run = 1'b0;
        checks++;
        if (first_done < 0 || lw2 - first_done !== 2) begin
            errors++;
            $display("FAIL b2b_restart_gap: got %0d cycles, expected 2", lw2 - first_done);
        end
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d dones, expected %0d", done_cnt, target); end
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_seq: got %0d, expected %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL b2b_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_back_to_back: two jobs, restart gap %0d", lw2 - first_done);
    endtask

`ifdef CLUSTER_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int e, o, target, dones, t;
        bit ok;
        cd_off = 1'b1;
        exp_q.push_back(1000);
        exp_q.push_back(2000);
        exp_q.push_back(3000);
        dones = done_cnt;
        pulse_run();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (start) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_reach_start: got no start, expected one"); end
        t = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            t++;
            if (!busy) break;
        end
        checks++;
        if (t !== 17) begin errors++; $display("FAIL timeout_latency: got %0d, expected 17", t); end
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout_error_set: got %b, expected 1", error); end
        checks++;
        if (done_cnt !== dones) begin errors++; $display("FAIL timeout_no_done: got %0d dones, expected %0d", done_cnt, dones); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL timeout_seq: got none, expected %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL timeout_seq: got %0d, expected %0d", o, e); end
            end
        end
        obs_q.delete();
        cd_off = 1'b0;
        target = done_cnt + 1;
        push_job();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_error_clear: got %b, expected 0", error); end
        wait_done(target, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_rerun: got %0d dones, expected %0d", done_cnt, target); end
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        $display("test_timeout: watchdog tripped after %0d cycles", t - 1);
    endtask
`endif

    initial begin
        reset = 1'b0;
        run = 1'b0;
        abort = 1'b0;
        load_done = 1'b0;
        compute_done = 1'b0;
        test_reset();
        test_nominal();
        test_stuck_load();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef CLUSTER_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cluster_ctrl.md
Name: cluster_ctrl

Overview:
- Top-level sequencer for one GLB/router/PE cluster slice.
- Replaces bench-driven sequencing. In order, it pulses the weight router load, the iact router load, PE cluster start per iteration, and psum router writeback.
- Runs NUM_ITER compute iterations per job and reports busy/done.
- Sits between the host/config side and router_weight, router_iact, router_psum and PE_cluster control pins.

Parameters:
- NUM_ITER, 3, compute iterations per job (act_size - kernel_size + 1); legal 1..2**ITER_BITWIDTH-1.
- ITER_BITWIDTH, 4, width of iteration counter.
- GAP_CYCLES, 4, idle cycles inserted between phases (settle time); legal 0..255.
- WB_CYCLES, 3, cycles write_psum_ctrl phase is held open (one per PE column, X_dim); legal 1..255.
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start-job request; sampled only in IDLE.
- abort  in  1  synchronous abort; any state -> IDLE next cycle.
- load_done  in  1  PE_cluster spad-load complete (level).
- compute_done  in  1  PE_cluster iteration complete (level).
- load_spad_ctrl  out  1  one-cycle pulse to router_weight.
- load_spad_ctrl_iact  out  1  one-cycle pulse to router_iact.
- start  out  1  one-cycle pulse to PE_cluster.
- write_psum_ctrl  out  1  level to router_psum during writeback.
- busy  out  1  high in every state except IDLE/DONE.
- done  out  1  one-cycle pulse on job completion.
- iter_cnt  out  ITER_BITWIDTH  current iteration index, 0-based.
- error  out  1  sticky watchdog flag (optional feature only; else tied 0).

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; iter_cnt 0; gap counter 0; edge registers 0.
- Done detection: load_done and compute_done are registered each cycle. Event = current & ~previous (rising edge). A level already high when a wait state is entered is not an event. This is required because load_done stays high across the two loads.
- States and transitions:
  - IDLE: run=1 -> LD_WGHT; iter_cnt<=0.
  - LD_WGHT: load_spad_ctrl=1 for exactly this cycle -> WT_WGHT.
  - WT_WGHT: on load_done event -> GAP1.
  - GAP1: count GAP_CYCLES -> LD_IACT (GAP_CYCLES=0: direct).
  - LD_IACT: load_spad_ctrl_iact=1 one cycle -> WT_IACT.
  - WT_IACT: on load_done event -> GAP2.
  - GAP2: count GAP_CYCLES -> START.
  - START: start=1 one cycle -> WT_COMP.
  - WT_COMP: on compute_done event -> WB.
  - WB: write_psum_ctrl=1 for WB_CYCLES consecutive cycles -> NEXT.
  - NEXT: if iter_cnt==NUM_ITER-1 -> DONE; else iter_cnt++ -> GAP2 (weights/iact not reloaded).
  - DONE: done=1 one cycle -> IDLE.
- Minimum latency, run to done with events arriving the cycle after entering a wait, GAP=0: 2+2+NUM_ITER*(2+WB_CYCLES+1)+1 cycles.
- Simultaneous events:
  - abort has priority over every transition, including run in IDLE.
  - Event in the same cycle as the issuing pulse: not possible; edge registers compare against the prior cycle. An event already in flight at state entry still counts.
- run held high: a new job starts only from IDLE, i.e. the cycle after done.
- run pulses while busy: ignored.
- Async reset mid-job: immediate IDLE, outputs 0; no partial done pulse.
- Abort: next cycle IDLE; all pulses and write_psum_ctrl drop; iter_cnt cleared; done not asserted.
- iter_cnt never wraps; NUM_ITER legality is checked by an elaboration assertion.

Optional Feature:
- Macro CLUSTER_CTRL_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entry to each WT_* state.
  - Reaching TIMEOUT_CYCLES in a WT_* state sets sticky error and moves to IDLE with no done pulse.
  - error clears only on reset or on run accepted in IDLE.
- Undefined: no counter; WT_* states wait indefinitely; error tied 0.

Decomposition:
- Package cluster_ctrl_pkg: state enum ctrl_state_t, phase-count width constant, default NUM_ITER/GAP_CYCLES/WB_CYCLES localparams shared with the top bench.
- Sub-module rise_detect (1-bit register plus edge output, async active-low reset), instantiated twice for load_done and compute_done.
- Counters and FSM stay in cluster_ctrl.

Test Plan:
- Nominal job: run pulse, model answers each load/compute 5 cycles after the request -> exactly one load_spad_ctrl, one load_spad_ctrl_iact, 3 start pulses, 3 write_psum_ctrl windows of 3 cycles each, iter_cnt 0,1,2, single done, busy low after.
- Stuck-high load_done: keep load_done=1 after the weight load -> controller stays in WT_IACT until load_done drops and rises again; only then load_spad_ctrl_iact ordering proceeds.
- Abort during WT_COMP of iteration 1 -> next cycle busy=0, iter_cnt=0, no done, no write_psum_ctrl; a following run restarts from the weight load.
- Async reset asserted mid-WB -> outputs 0 immediately, without waiting for a clk edge; release and run -> full nominal sequence.
- run held high for 100 cycles -> back-to-back jobs; a second load_spad_ctrl appears exactly 2 cycles after the first done.
- With CLUSTER_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, compute_done never asserted -> error=1 and busy=0 after 16 cycles in WT_COMP; no done; next accepted run clears error.
